// File: rtl/mem_data_demux_ncl_seq.sv
// rtl/mem_data_demux_ncl_seq.sv - clocked dual-rail memory word demux with DATA/NULL wavefront FSM
// Optional illegal-code (both rails high) detection under `MEM_DEMUX_RAIL_CHECK_EN.
module mem_data_demux_ncl_seq #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_t,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_f,
  input  logic [DATA_W-1:0]                              d_t,
  input  logic [DATA_W-1:0]                              d_f,
  output logic                                           ko,
  input  logic [NUM_CH-1:0]                              ki,
  output logic [NUM_CH*DATA_W-1:0]                       out_t,
  output logic [NUM_CH*DATA_W-1:0]                       out_f,
  output logic                                           err
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     ko_q, ko_d;
  logic                     err_q, err_d;
  logic                     oor_q, oor_d;
  logic [SEL_W-1:0]         ch_q, ch_d;
  logic [NUM_CH*DATA_W-1:0] out_t_q, out_t_d;
  logic [NUM_CH*DATA_W-1:0] out_f_q, out_f_d;

  logic data_complete;
  logic null_complete;
  logic illegal;
  logic in_range;
  logic ki_sel;
  logic ki_held;

  // A both-high pair fails the XOR test, so it always reads as partial.
  assign data_complete = (&(sel_t ^ sel_f)) & (&(d_t ^ d_f));
  assign null_complete = ~(|{sel_t, sel_f, d_t, d_f});
`ifdef MEM_DEMUX_RAIL_CHECK_EN
  assign illegal = (|(sel_t & sel_f)) | (|(d_t & d_f));
`else
  assign illegal = 1'b0;
`endif

  assign in_range = ({{(32-SEL_W){1'b0}}, sel_t} < NUM_CH);
  assign ki_sel   = in_range ? ki[sel_t] : 1'b0;
  assign ki_held  = ki[ch_q];

  always_comb begin
    state_d = state_q;
    ko_d    = ko_q;
    err_d   = err_q | illegal;
    oor_d   = oor_q;
    ch_d    = ch_q;
    out_t_d = out_t_q;
    out_f_d = out_f_q;
    case (state_q)
      S_NULL: begin
        if (data_complete && !in_range) begin
          err_d   = 1'b1;
          oor_d   = 1'b1;
          state_d = S_DATA;
          ko_d    = 1'b0;
        end else if (data_complete && ki_sel) begin
          oor_d   = 1'b0;
          ch_d    = sel_t;
          state_d = S_DATA;
          ko_d    = 1'b0;
          for (int c = 0; c < NUM_CH; c++) begin
            if (sel_t == c[SEL_W-1:0]) begin
              out_t_d[c*DATA_W +: DATA_W] = d_t;
              out_f_d[c*DATA_W +: DATA_W] = d_f;
            end else begin
              out_t_d[c*DATA_W +: DATA_W] = '0;
              out_f_d[c*DATA_W +: DATA_W] = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (null_complete && (oor_q || !ki_held)) begin
          out_t_d = '0;
          out_f_d = '0;
          oor_d   = 1'b0;
          state_d = S_NULL;
          ko_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_NULL;
        ko_d    = 1'b1;
        out_t_d = '0;
        out_f_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NULL;
      ko_q    <= 1'b1;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      ch_q    <= '0;
      out_t_q <= '0;
      out_f_q <= '0;
    end else begin
      state_q <= state_d;
      ko_q    <= ko_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
      ch_q    <= ch_d;
      out_t_q <= out_t_d;
      out_f_q <= out_f_d;
    end
  end

  assign ko    = ko_q;
  assign err   = err_q;
  assign out_t = out_t_q;
  assign out_f = out_f_q;

endmodule

// File: tb/tb_mem_data_demux_ncl_seq.sv
// tb/tb_mem_data_demux_ncl_seq.sv - directed bench for mem_data_demux_ncl_seq (2- and 3-channel builds)
module tb_mem_data_demux_ncl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 2-channel instance
  logic        rst_na;
  logic [0:0]  sel_ta, sel_fa;
  logic [7:0]  d_ta, d_fa;
  logic [1:0]  ki_a;
  logic        ko_a, err_a;
  logic [15:0] out_ta, out_fa;

  // 3-channel instance
  logic        rst_nb;
  logic [1:0]  sel_tb, sel_fb;
  logic [7:0]  d_tb, d_fb;
  logic [2:0]  ki_b;
  logic        ko_b, err_b;
  logic [23:0] out_tb, out_fb;

  mem_data_demux_ncl_seq #(.DATA_W(8), .NUM_CH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_na), .sel_t(sel_ta), .sel_f(sel_fa),
    .d_t(d_ta), .d_f(d_fa), .ko(ko_a), .ki(ki_a),
    .out_t(out_ta), .out_f(out_fa), .err(err_a)
  );

  mem_data_demux_ncl_seq #(.DATA_W(8), .NUM_CH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_nb), .sel_t(sel_tb), .sel_f(sel_fb),
    .d_t(d_tb), .d_f(d_fb), .ko(ko_b), .ki(ki_b),
    .out_t(out_tb), .out_f(out_fb), .err(err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word_a(input logic s, input logic [7:0] v);
    sel_ta = s; sel_fa = ~s; d_ta = v; d_fa = ~v;
  endtask

  task automatic null_a();
    sel_ta = '0; sel_fa = '0; d_ta = '0; d_fa = '0;
  endtask

  task automatic test_reset();
    rst_na = 1'b0; rst_nb = 1'b0;
    null_a(); ki_a = '0;
    sel_tb = '0; sel_fb = '0; d_tb = '0; d_fb = '0; ki_b = '0;
    step(); step();
    n_vec++;
    if ({ko_a, err_a, out_ta, out_fa} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_a: ko=%b err=%b out_t=%h out_f=%h, want ko=1 err=0 out=0", ko_a, err_a, out_ta, out_fa);
    end
    n_vec++;
    if ({ko_b, err_b, out_tb, out_fb} !== {1'b1, 1'b0, 48'h0}) begin
      n_err++;
      $display("FAIL reset_b: ko=%b err=%b out_t=%h out_f=%h, want ko=1 err=0 out=0", ko_b, err_b, out_tb, out_fb);
    end
    @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1;
    step();
  endtask

  task automatic test_route();
    word_a(1'b1, 8'hA5); ki_a = 2'b11;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {16'hA500, 16'h5A00, 1'b0}) begin
      n_err++;
      $display("FAIL route_ch1: out_t=%h out_f=%h ko=%b, want a500 5a00 0", out_ta, out_fa, ko_a);
    end
    word_a(1'b0, 8'hFF);
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {16'hA500, 16'h5A00, 1'b0}) begin
      n_err++;
      $display("FAIL route_hold: out_t=%h out_f=%h ko=%b, want a500 5a00 0", out_ta, out_fa, ko_a);
    end
    null_a(); ki_a = 2'b01;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL route_null: out_t=%h out_f=%h ko=%b, want 0 0 1", out_ta, out_fa, ko_a);
    end
    word_a(1'b0, 8'h3C); ki_a = 2'b11;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {16'h003C, 16'h00C3, 1'b0}) begin
      n_err++;
      $display("FAIL route_ch0: out_t=%h out_f=%h ko=%b, want 003c 00c3 0", out_ta, out_fa, ko_a);
    end
    null_a(); ki_a = 2'b10;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a, err_a} !== {32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL route_null0: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 0", out_ta, out_fa, ko_a, err_a);
    end
  endtask

  task automatic test_ki_stall();
    word_a(1'b1, 8'h12); ki_a = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({out_ta, out_fa, ko_a} !== {32'h0, 1'b1}) begin
        n_err++;
        $display("FAIL ki_stall[%0d]: out_t=%h out_f=%h ko=%b, want 0 0 1", i, out_ta, out_fa, ko_a);
      end
    end
    ki_a = 2'b10;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {16'h1200, 16'hED00, 1'b0}) begin
      n_err++;
      $display("FAIL ki_release: out_t=%h out_f=%h ko=%b, want 1200 ed00 0", out_ta, out_fa, ko_a);
    end
    null_a(); ki_a = 2'b00;
    step();
  endtask

  task automatic test_partial();
    ki_a = 2'b11;
    sel_ta = 1'b0; sel_fa = 1'b1; d_ta = 8'h05; d_fa = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({out_ta, out_fa, ko_a} !== {32'h0, 1'b1}) begin
        n_err++;
        $display("FAIL partial[%0d]: out_t=%h out_f=%h ko=%b, want 0 0 1", i, out_ta, out_fa, ko_a);
      end
    end
    d_ta = 8'hC5; d_fa = 8'h3A;
    step();
    n_vec++;
    if ({out_ta, out_fa, ko_a} !== {16'h00C5, 16'h003A, 1'b0}) begin
      n_err++;
      $display("FAIL partial_done: out_t=%h out_f=%h ko=%b, want 00c5 003a 0", out_ta, out_fa, ko_a);
    end
    null_a(); ki_a = 2'b00;
    step();
  endtask

  task automatic test_rail();
    ki_a = 2'b11;
    sel_ta = 1'b0; sel_fa = 1'b1; d_ta = 8'h04; d_fa = 8'hFF;
    step();
    n_vec++;
`ifdef MEM_DEMUX_RAIL_CHECK_EN
    if ({out_ta, out_fa, ko_a, err_a} !== {32'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL rail_check: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 1", out_ta, out_fa, ko_a, err_a);
    end
`else
    if ({out_ta, out_fa, ko_a, err_a} !== {32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rail_partial: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 0", out_ta, out_fa, ko_a, err_a);
    end
`endif
    null_a(); ki_a = 2'b00;
    step();
  endtask

  task automatic test_out_of_range();
    sel_tb = 2'b11; sel_fb = 2'b00; d_tb = 8'h77; d_fb = 8'h88; ki_b = 3'b111;
    step();
    n_vec++;
    if ({out_tb, out_fb, ko_b, err_b} !== {48'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL oor_set: out_t=%h out_f=%h ko=%b err=%b, want 0 0 0 1", out_tb, out_fb, ko_b, err_b);
    end
    sel_tb = '0; sel_fb = '0; d_tb = '0; d_fb = '0;
    step();
    n_vec++;
    if ({out_tb, out_fb, ko_b, err_b} !== {48'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL oor_null: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 1", out_tb, out_fb, ko_b, err_b);
    end
    sel_tb = 2'b10; sel_fb = 2'b01; d_tb = 8'h81; d_fb = 8'h7E; ki_b = 3'b100;
    step();
    n_vec++;
    if ({out_tb, out_fb, ko_b, err_b} !== {24'h810000, 24'h7E0000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL ch2_route: out_t=%h out_f=%h ko=%b err=%b, want 810000 7e0000 0 1", out_tb, out_fb, ko_b, err_b);
    end
    sel_tb = '0; sel_fb = '0; d_tb = '0; d_fb = '0; ki_b = 3'b000;
    step();
    n_vec++;
    if ({out_tb, out_fb, ko_b, err_b} !== {48'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ch2_null: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 1", out_tb, out_fb, ko_b, err_b);
    end
  endtask

  task automatic test_async_reset();
    word_a(1'b1, 8'h5A); ki_a = 2'b11;
    step();
    n_vec++;
    if ({out_ta, ko_a} !== {16'h5A00, 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset: out_t=%h ko=%b, want 5a00 0", out_ta, ko_a);
    end
    #1 rst_na = 1'b0;
    #1;
    n_vec++;
    if ({out_ta, out_fa, ko_a, err_a} !== {32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: out_t=%h out_f=%h ko=%b err=%b, want 0 0 1 0", out_ta, out_fa, ko_a, err_a);
    end
    null_a(); ki_a = 2'b00;
    @(negedge clk);
    rst_na = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_route();
    test_ki_stall();
    test_partial();
    test_rail();
    test_out_of_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
